regfile_sb: RTL and testbench

Scoreboarded register file for the pipelined RV32I core. It provides two combinational read ports, one write port and optional write-to-read bypass. It also holds a per-register busy scoreboard that tracks outstanding writebacks and produces a decode-stage stall. The block sits between decode (reads, issue) and writeback (write), and keeps a registered `a0` mirror for the top-level test output.

---
 rtl/regfile_sb.sv | 109 ++++++++++
 tb/tb_regfile_sb.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: scoreboarded register file for the pipelined RV32I core.
//
// Two combinational read ports, one write port, optional same-cycle
// writeback-to-read forwarding, a per-register busy scoreboard that
// produces the decode-stage stall, and a registered mirror of one register.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   rs1/rs2 -> rd1/rd2  read addresses / combinational read data
//   we, wa, wd        writeback enable, address, data
//   issue_valid       decode presents an instruction this cycle
//   issue_use1/2      instruction reads rs1 / rs2
//   issue_wen         instruction will write issue_rd
//   issue_rd          destination of the issuing instruction
//   stall             issue blocked this cycle (combinational)
//   busy              scoreboard, bit i = write to xi outstanding
//   a0                registered copy of register A0_INDEX
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS     = 1'b1,
  parameter int A0_INDEX   = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_WIDTH-1:0]      rs1,
  input  logic [ADDR_WIDTH-1:0]      rs2,
  output logic [DATA_WIDTH-1:0]      rd1,
  output logic [DATA_WIDTH-1:0]      rd2,
  input  logic                       we,
  input  logic [ADDR_WIDTH-1:0]      wa,
  input  logic [DATA_WIDTH-1:0]      wd,
  input  logic                       issue_valid,
  input  logic                       issue_use1,
  input  logic                       issue_use2,
  input  logic                       issue_wen,
  input  logic [ADDR_WIDTH-1:0]      issue_rd,
  output logic                       stall,
  output logic [(2**ADDR_WIDTH)-1:0] busy,
  output logic [DATA_WIDTH-1:0]      a0
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] A0_ADDR = ADDR_WIDTH'(A0_INDEX);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]      busy_q, busy_d;
  logic [DATA_WIDTH-1:0] a0_q, a0_d;

  logic fwd1, fwd2;
  logic hazard1, hazard2, hazard_waw;
  logic fire;

  // A writeback hitting a read address this cycle; only meaningful with BYPASS.
  assign fwd1 = BYPASS && we && (wa == rs1);
  assign fwd2 = BYPASS && we && (wa == rs2);

  // Reset forces reads to zero immediately, before the array clear lands,
  // so a forwarded wd cannot leak out while rst is high.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (!rst && rs1 != '0) rd1 = fwd1 ? wd : mem_q[rs1];
    if (!rst && rs2 != '0) rd2 = fwd2 ? wd : mem_q[rs2];
  end

  // busy_q[0] is held at 0, so x0 sources never raise a hazard.
  assign hazard1    = issue_use1 && busy_q[rs1] && !fwd1;
  assign hazard2    = issue_use2 && busy_q[rs2] && !fwd2;
  // A same-cycle writeback to issue_rd deliberately does not clear WAW.
  assign hazard_waw = issue_wen && busy_q[issue_rd] && (issue_rd != '0);
  assign stall      = issue_valid && (hazard1 || hazard2 || hazard_waw);
  assign fire       = issue_valid && !stall;

  always_comb begin
    mem_d = mem_q;
    if (we && wa != '0) mem_d[wa] = wd;
  end

  // Clear applied first, set second: set wins on a same-register collision.
  always_comb begin
    busy_d = busy_q;
    if (we) busy_d[wa] = 1'b0;
    if (fire && issue_wen) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    a0_d = a0_q;
    if (we && wa == A0_ADDR) a0_d = wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q <= '0;
      a0_q   <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
      a0_q   <= a0_d;
    end
  end

  assign busy = busy_q;
  assign a0   = a0_q;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1 = '0, rs2 = '0, wa = '0, issue_rd = '0;
  logic        we = 1'b0, issue_valid = 1'b0, issue_use1 = 1'b0;
  logic        issue_use2 = 1'b0, issue_wen = 1'b0;
  logic [31:0] wd = '0;

  logic [31:0] rd1_b, rd2_b, a0_b, busy_b;
  logic [31:0] rd1_n, rd2_n, a0_n, busy_n;
  logic        stall_b, stall_n;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b1), .A0_INDEX(10)) dut_b (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd1(rd1_b), .rd2(rd2_b),
    .we(we), .wa(wa), .wd(wd), .issue_valid(issue_valid), .issue_use1(issue_use1),
    .issue_use2(issue_use2), .issue_wen(issue_wen), .issue_rd(issue_rd),
    .stall(stall_b), .busy(busy_b), .a0(a0_b));

  regfile_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0), .A0_INDEX(10)) dut_n (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd1(rd1_n), .rd2(rd2_n),
    .we(we), .wa(wa), .wd(wd), .issue_valid(issue_valid), .issue_use1(issue_use1),
    .issue_use2(issue_use2), .issue_wen(issue_wen), .issue_rd(issue_rd),
    .stall(stall_n), .busy(busy_n), .a0(a0_n));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  rs1, rs2;
    logic        iv, u1, u2, wen;
    logic [4:0]  ird;
    logic [31:0] rd1_b, rd1_n, rd2_b, rd2_n;
    logic        st_b, st_n;
    logic [31:0] busy;
    logic [31:0] a0;
  } vec_t;

  vec_t vt [14];

  function automatic vec_t mk(logic w, logic [4:0] a, logic [31:0] d, logic [4:0] r1,
                              logic [4:0] r2, logic iv, logic u1, logic u2, logic wen,
                              logic [4:0] ird, logic [31:0] e1b, logic [31:0] e1n,
                              logic [31:0] e2b, logic [31:0] e2n, logic sb, logic sn,
                              logic [31:0] bz, logic [31:0] a0v);
    vec_t v;
    v.we = w; v.wa = a; v.wd = d; v.rs1 = r1; v.rs2 = r2;
    v.iv = iv; v.u1 = u1; v.u2 = u2; v.wen = wen; v.ird = ird;
    v.rd1_b = e1b; v.rd1_n = e1n; v.rd2_b = e2b; v.rd2_n = e2n;
    v.st_b = sb; v.st_n = sn; v.busy = bz; v.a0 = a0v;
    return v;
  endfunction

  // Reference model state; one scoreboard per bypass flavour since stalls differ.
  logic [31:0] m_mem [32];
  bit          m_busy [2][32];
  logic [31:0] m_a0;

  function automatic logic [31:0] m_read(int addr, bit byp);
    if (addr == 0) return 32'h0;
    if (byp && we && int'(wa) == addr) return wd;
    return m_mem[addr];
  endfunction

  function automatic bit m_stall(int f);
    bit byp = (f == 0);
    bit h1, h2, hw;
    h1 = issue_use1 && m_busy[f][rs1] && !(byp && we && wa == rs1);
    h2 = issue_use2 && m_busy[f][rs2] && !(byp && we && wa == rs2);
    hw = issue_wen && (issue_rd != 0) && m_busy[f][issue_rd];
    return issue_valid && (h1 || h2 || hw);
  endfunction

  function automatic logic [31:0] m_busy_vec(int f);
    logic [31:0] v = '0;
    for (int i = 1; i < 32; i++) v[i] = m_busy[f][i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = '0; m_busy[0][i] = 0; m_busy[1][i] = 0;
    end
    m_a0 = '0;
  endtask

  task automatic idle();
    we = 0; wa = '0; wd = '0; rs1 = '0; rs2 = '0;
    issue_valid = 0; issue_use1 = 0; issue_use2 = 0; issue_wen = 0; issue_rd = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vt[0]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 32'h0, 0);
    vt[1]  = mk(1, 7, 32'h12345678, 0, 7, 0, 0, 0, 0, 0,  0, 0, 32'h12345678, 0, 0, 0, 32'h0, 0);
    vt[2]  = mk(0, 0, 0, 0, 7, 1, 0, 0, 1, 3,  0, 0, 32'h12345678, 32'h12345678, 0, 0, 32'h0, 0);
    vt[3]  = mk(0, 0, 0, 3, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 1, 1, 32'h8, 0);
    vt[4]  = mk(1, 3, 32'hAAAA5555, 3, 0, 1, 1, 0, 0, 0,  32'hAAAA5555, 0, 0, 0, 0, 1, 32'h8, 0);
    vt[5]  = mk(0, 0, 0, 3, 0, 1, 1, 0, 0, 0,  32'hAAAA5555, 32'hAAAA5555, 0, 0, 0, 0, 32'h0, 0);
    vt[6]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 4,  0, 0, 0, 0, 0, 0, 32'h0, 0);
    vt[7]  = mk(1, 4, 32'h44, 0, 0, 1, 0, 0, 1, 4,  0, 0, 0, 0, 1, 1, 32'h10, 0);
    vt[8]  = mk(0, 0, 0, 4, 0, 1, 0, 0, 1, 4,  32'h44, 32'h44, 0, 0, 0, 0, 32'h0, 0);
    vt[9]  = mk(1, 10, 32'h2A, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 32'h10, 0);
    vt[10] = mk(1, 11, 32'h99, 10, 11, 0, 0, 0, 0, 0,  32'h2A, 32'h2A, 32'h99, 0, 0, 0, 32'h10, 32'h2A);
    vt[11] = mk(0, 0, 0, 11, 10, 0, 0, 0, 0, 0,  32'h99, 32'h99, 32'h2A, 32'h2A, 0, 0, 32'h10, 32'h2A);
    vt[12] = mk(1, 5, 32'h55, 5, 0, 1, 0, 0, 1, 5,  32'h55, 0, 0, 0, 0, 0, 32'h10, 32'h2A);
    vt[13] = mk(0, 0, 0, 5, 0, 0, 0, 0, 0, 0,  32'h55, 32'h55, 0, 0, 0, 0, 32'h30, 32'h2A);

    idle();
    rst = 1'b1;
    #2;
    chk("reset_busy", busy_b, 32'h0);
    chk("reset_a0", a0_b, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      we = vt[i].we; wa = vt[i].wa; wd = vt[i].wd; rs1 = vt[i].rs1; rs2 = vt[i].rs2;
      issue_valid = vt[i].iv; issue_use1 = vt[i].u1; issue_use2 = vt[i].u2;
      issue_wen = vt[i].wen; issue_rd = vt[i].ird;
      #1;
      chk($sformatf("vec%0d_rd1_byp", i), rd1_b, vt[i].rd1_b);
      chk($sformatf("vec%0d_rd1_nobyp", i), rd1_n, vt[i].rd1_n);
      chk($sformatf("vec%0d_rd2_byp", i), rd2_b, vt[i].rd2_b);
      chk($sformatf("vec%0d_rd2_nobyp", i), rd2_n, vt[i].rd2_n);
      chk($sformatf("vec%0d_stall_byp", i), 32'(stall_b), 32'(vt[i].st_b));
      chk($sformatf("vec%0d_stall_nobyp", i), 32'(stall_n), 32'(vt[i].st_n));
      chk($sformatf("vec%0d_busy_byp", i), busy_b, vt[i].busy);
      chk($sformatf("vec%0d_busy_nobyp", i), busy_n, vt[i].busy);
      chk($sformatf("vec%0d_a0", i), a0_b, vt[i].a0);
      chk($sformatf("vec%0d_a0_nobyp", i), a0_n, vt[i].a0);
    end

    // Mid-cycle reset with x5 holding data and busy[5] outstanding.
    @(negedge clk);
    idle(); we = 1; wa = 5; wd = 32'hDEADBEEF;
    @(negedge clk);
    idle(); issue_valid = 1; issue_wen = 1; issue_rd = 5;
    @(negedge clk);
    idle(); rs1 = 5;
    #1;
    chk("pre_rst_rd1", rd1_b, 32'hDEADBEEF);
    chk("pre_rst_busy", busy_b, 32'h30);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_rd1_byp", rd1_b, 32'h0);
    chk("rst_rd1_nobyp", rd1_n, 32'h0);
    chk("rst_busy_byp", busy_b, 32'h0);
    chk("rst_busy_nobyp", busy_n, 32'h0);
    chk("rst_a0", a0_b, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    we = 1; wa = 6; wd = 32'h66; rs1 = 6;
    #1;
    chk("post_rst_fwd_byp", rd1_b, 32'h66);
    chk("post_rst_fwd_nobyp", rd1_n, 32'h0);
    @(negedge clk);
    idle(); rs1 = 6; rs2 = 5;
    #1;
    chk("post_rst_rd1", rd1_n, 32'h66);
    chk("post_rst_rd2_cleared", rd2_n, 32'h0);
    chk("post_rst_busy", busy_b, 32'h0);

    // Randomized run against the reference model.
    pulse_reset();
    model_clear();
    for (int c = 0; c < 600; c++) begin
      bit st[2];
      @(negedge clk);
      we = ($urandom_range(0, 1) == 1);
      wa = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 11));
      wd = $urandom;
      rs1 = 5'($urandom_range(0, 11));
      rs2 = 5'($urandom_range(0, 11));
      issue_valid = ($urandom_range(0, 9) < 7);
      issue_use1 = $urandom_range(0, 1) == 1;
      issue_use2 = $urandom_range(0, 1) == 1;
      issue_wen = $urandom_range(0, 1) == 1;
      issue_rd = 5'($urandom_range(0, 11));
      #1;
      for (int f = 0; f < 2; f++) st[f] = m_stall(f);
      chk("rnd_rd1_byp", rd1_b, m_read(int'(rs1), 1));
      chk("rnd_rd2_byp", rd2_b, m_read(int'(rs2), 1));
      chk("rnd_rd1_nobyp", rd1_n, m_read(int'(rs1), 0));
      chk("rnd_rd2_nobyp", rd2_n, m_read(int'(rs2), 0));
      chk("rnd_stall_byp", 32'(stall_b), 32'(st[0]));
      chk("rnd_stall_nobyp", 32'(stall_n), 32'(st[1]));
      chk("rnd_busy_byp", busy_b, m_busy_vec(0));
      chk("rnd_busy_nobyp", busy_n, m_busy_vec(1));
      chk("rnd_a0", a0_b, m_a0);
      // Next-state per the architectural rules: set on a fired issue wins over clear.
      for (int f = 0; f < 2; f++) begin
        for (int r = 1; r < 32; r++) begin
          if (issue_valid && !st[f] && issue_wen && int'(issue_rd) == r) m_busy[f][r] = 1;
          else if (we && int'(wa) == r) m_busy[f][r] = 0;
        end
      end
      if (we && wa != 0) m_mem[wa] = wd;
      if (we && wa == 5'd10) m_a0 = wd;
    end

    @(negedge clk);
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
